// File: rtl/projectile_move.sv
// Player projectile: launch from the ship, climb SPEED pixels per frame, explode or vanish on a hit.
// Define PROJECTILE_EXPLODE_EN to enable the timed explosion; otherwise a hit returns straight to IDLE.
module projectile_move #(
  parameter int          SPEED          = 4,
  parameter int          PROJ_W         = 4,
  parameter int          PROJ_H         = 8,
  parameter int          LAUNCH_X_OFS   = 14,
  parameter logic [7:0]  FLY_COLOR      = 8'hFC,
  parameter logic [7:0]  EXPLODE_COLOR  = 8'hE0,
  parameter int          EXPLODE_FRAMES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        fire,
  input  logic [10:0] shipX,
  input  logic [10:0] shipY,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        collision,
  input  logic        gameOver,
  output logic        projectileDrawingRequest,
  output logic [7:0]  projectileRGB,
  output logic        busy,
  output logic [7:0]  hitCount
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    FLYING  = 2'd2,
    EXPLODE = 2'd3
  } state_e;

  localparam logic [11:0] SPEED_C = 12'(SPEED);
  localparam logic [11:0] W_C     = 12'(PROJ_W);
  localparam logic [11:0] H_C     = 12'(PROJ_H);
  localparam logic [11:0] OFS_C   = 12'(LAUNCH_X_OFS);

`ifdef PROJECTILE_EXPLODE_EN
  localparam int              CNT_W    = (EXPLODE_FRAMES > 1) ? $clog2(EXPLODE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXPLODE_FRAMES - 1);
  logic [CNT_W-1:0] frame_cnt_q;
`endif

  state_e      state_q;
  logic [11:0] x_q;
  logic [10:0] top_y_q;
  logic [7:0]  hit_q;
  logic        draw_q;
  logic [7:0]  rgb_q;

  // All box arithmetic is 12 bits wide so the right/bottom edges never wrap near pixel 2047.
  logic [11:0] px_ext, py_ext, top_y_ext, ship_x_ext, ship_y_ext;
  logic        in_box_d, visible_d, can_launch_d, can_step_d;
  logic [11:0] launch_x_d;
  logic [10:0] launch_y_d, step_y_d;
  logic [7:0]  color_d;

  always_comb begin
    px_ext       = {1'b0, pixelX};
    py_ext       = {1'b0, pixelY};
    top_y_ext    = {1'b0, top_y_q};
    ship_x_ext   = {1'b0, shipX};
    ship_y_ext   = {1'b0, shipY};
    in_box_d     = (px_ext >= x_q) && (px_ext <= x_q + W_C - 12'd1) &&
                   (py_ext >= top_y_ext) && (py_ext <= top_y_ext + H_C - 12'd1);
    visible_d    = ((state_q == FLYING) || (state_q == EXPLODE)) && in_box_d && !gameOver;
    color_d      = (state_q == EXPLODE) ? EXPLODE_COLOR : FLY_COLOR;
    can_launch_d = ship_y_ext >= H_C;
    launch_x_d   = ship_x_ext + OFS_C;
    launch_y_d   = 11'(ship_y_ext - H_C);
    can_step_d   = top_y_ext >= SPEED_C;
    step_y_d     = 11'(top_y_ext - SPEED_C);
  end

  // NOTE: every register here is written with <= so all state updates see the pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      x_q         <= '0;
      top_y_q     <= '0;
      hit_q       <= '0;
      draw_q      <= 1'b0;
      rgb_q       <= 8'h00;
`ifdef PROJECTILE_EXPLODE_EN
      frame_cnt_q <= '0;
`endif
    end else begin
      draw_q <= visible_d;
      rgb_q  <= visible_d ? color_d : 8'h00;

      if (gameOver) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (fire && can_launch_d) begin
              x_q     <= launch_x_d;
              top_y_q <= launch_y_d;
              state_q <= ARMED;
            end
          end
          ARMED: begin
            if (startOfFrame) state_q <= FLYING;
          end
          FLYING: begin
            // A hit in the same cycle as a frame tick wins; the position is frozen.
            if (collision) begin
              if (hit_q != 8'hFF) hit_q <= hit_q + 8'd1;
`ifdef PROJECTILE_EXPLODE_EN
              state_q     <= EXPLODE;
              frame_cnt_q <= '0;
`else
              state_q     <= IDLE;
`endif
            end else if (startOfFrame) begin
              if (can_step_d) top_y_q <= step_y_d;
              else            state_q <= IDLE;
            end
          end
          EXPLODE: begin
`ifdef PROJECTILE_EXPLODE_EN
            if (startOfFrame) begin
              if (frame_cnt_q == CNT_LAST) state_q     <= IDLE;
              else                         frame_cnt_q <= frame_cnt_q + CNT_W'(1);
            end
`else
            state_q <= IDLE;
`endif
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign projectileDrawingRequest = draw_q;
  assign projectileRGB            = rgb_q;
  assign busy                     = (state_q != IDLE);
  assign hitCount                 = hit_q;

endmodule

// File: tb/tb_projectile_move.sv
// Directed plus randomized bench for projectile_move against a frame-level behavioural model.
module tb_projectile_move;

  localparam int SPEED          = 4;
  localparam int PROJ_W         = 4;
  localparam int PROJ_H         = 8;
  localparam int LAUNCH_X_OFS   = 14;
  localparam int EXPLODE_FRAMES = 8;

  localparam int M_IDLE = 0, M_ARMED = 1, M_FLY = 2, M_EXP = 3;

  logic        clk = 1'b0;
  logic        reset, startOfFrame, fire, collision, gameOver;
  logic [10:0] shipX, shipY, pixelX, pixelY;
  logic        projectileDrawingRequest, busy;
  logic [7:0]  projectileRGB, hitCount;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: projectile mode, box position, explosion frames left, hits.
  int m_mode = M_IDLE;
  int m_x = 0, m_y = 0, m_left = 0, m_hits = 0;

  always #5 clk = ~clk;

  projectile_move dut (
    .clk                      (clk),
    .reset                    (reset),
    .startOfFrame             (startOfFrame),
    .fire                     (fire),
    .shipX                    (shipX),
    .shipY                    (shipY),
    .pixelX                   (pixelX),
    .pixelY                   (pixelY),
    .collision                (collision),
    .gameOver                 (gameOver),
    .projectileDrawingRequest (projectileDrawingRequest),
    .projectileRGB            (projectileRGB),
    .busy                     (busy),
    .hitCount                 (hitCount)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // Predict the registered outputs, advance the model, clock the DUT, compare, drop pulses.
  task automatic tick();
    int   px = int'(pixelX);
    int   py = int'(pixelY);
    int   sx = int'(shipX);
    int   sy = int'(shipY);
    bit   e_draw;
    logic [7:0] e_rgb;
    e_draw = !reset && !gameOver && (m_mode == M_FLY || m_mode == M_EXP) &&
             px >= m_x && px < m_x + PROJ_W && py >= m_y && py < m_y + PROJ_H;
    e_rgb  = !e_draw ? 8'h00 : (m_mode == M_EXP) ? 8'hE0 : 8'hFC;

    if (reset) begin
      m_mode = M_IDLE; m_x = 0; m_y = 0; m_left = 0; m_hits = 0;
    end else if (gameOver) begin
      m_mode = M_IDLE;
    end else if (m_mode == M_IDLE) begin
      if (fire && sy >= PROJ_H) begin
        m_x = sx + LAUNCH_X_OFS; m_y = sy - PROJ_H; m_mode = M_ARMED;
      end
    end else if (m_mode == M_ARMED) begin
      if (startOfFrame) m_mode = M_FLY;
    end else if (m_mode == M_FLY) begin
      if (collision) begin
        m_hits = (m_hits < 255) ? m_hits + 1 : 255;
`ifdef PROJECTILE_EXPLODE_EN
        m_mode = M_EXP; m_left = EXPLODE_FRAMES;
`else
        m_mode = M_IDLE;
`endif
      end else if (startOfFrame) begin
        if (m_y >= SPEED) m_y = m_y - SPEED;
        else              m_mode = M_IDLE;
      end
    end else begin
      if (startOfFrame) begin
        m_left = m_left - 1;
        if (m_left == 0) m_mode = M_IDLE;
      end
    end

    @(posedge clk);
    #1;
    check("busy", {7'b0, busy}, 8'(m_mode != M_IDLE));
    check("draw", {7'b0, projectileDrawingRequest}, {7'b0, e_draw});
    check("rgb", projectileRGB, e_rgb);
    check("hits", hitCount, 8'(m_hits));
    fire = 1'b0; startOfFrame = 1'b0; collision = 1'b0;
  endtask

  task automatic launch(input int sx, input int sy);
    shipX = 11'(sx); shipY = 11'(sy); fire = 1'b1; tick();
    startOfFrame = 1'b1; tick();
  endtask

  initial begin
    reset = 1'b1; startOfFrame = 1'b0; fire = 1'b0; collision = 1'b0; gameOver = 1'b0;
    shipX = '0; shipY = '0; pixelX = '0; pixelY = '0;
    tick(); tick();
    check("reset_rgb", projectileRGB, 8'h00);
    check("reset_busy", {7'b0, busy}, 8'h00);
    reset = 1'b0;

    // Launch at (300,440): box at X=314, topY=432.
    pixelX = 11'd314; pixelY = 11'd432;
    shipX = 11'd300; shipY = 11'd440; fire = 1'b1; tick();
    check("armed_busy", {7'b0, busy}, 8'h01);
    check("armed_nodraw", {7'b0, projectileDrawingRequest}, 8'h00);
    startOfFrame = 1'b1; tick();
    tick();
    check("fly_corner_draw", {7'b0, projectileDrawingRequest}, 8'h01);
    check("fly_corner_rgb", projectileRGB, 8'hFC);
    pixelX = 11'd318; tick();
    check("right_out_draw", {7'b0, projectileDrawingRequest}, 8'h00);
    check("right_out_rgb", projectileRGB, 8'h00);
    pixelX = 11'd317; pixelY = 11'd439; tick();
    check("bottom_right_in", {7'b0, projectileDrawingRequest}, 8'h01);
    pixelY = 11'd440; tick();
    check("bottom_out", {7'b0, projectileDrawingRequest}, 8'h00);
    startOfFrame = 1'b1; tick();
    pixelX = 11'd314; pixelY = 11'd428; tick();
    check("moved_top_in", {7'b0, projectileDrawingRequest}, 8'h01);
    pixelY = 11'd427; tick();
    check("moved_above_out", {7'b0, projectileDrawingRequest}, 8'h00);

    // Fly off the top of the screen.
    for (int i = 0; i < 200 && m_mode != M_IDLE; i++) begin
      startOfFrame = 1'b1; tick();
    end
    check("flew_out_idle", {7'b0, busy}, 8'h00);

    // topY=2: next frame retires the projectile instead of wrapping.
    launch(300, 10);
    pixelX = 11'd314; pixelY = 11'd2; tick();
    check("top2_draw", {7'b0, projectileDrawingRequest}, 8'h01);
    startOfFrame = 1'b1; tick();
    check("top2_retired", {7'b0, busy}, 8'h00);
    pixelY = 11'd2046; tick();
    check("no_wrap_draw", {7'b0, projectileDrawingRequest}, 8'h00);

    // Launch boundary on shipY.
    shipY = 11'd7; fire = 1'b1; tick();
    check("low_ship_ignored", {7'b0, busy}, 8'h00);
    shipY = 11'd8; fire = 1'b1; tick();
    check("ship_at_h_launch", {7'b0, busy}, 8'h01);
    gameOver = 1'b1; tick(); gameOver = 1'b0;

    // gameOver while flying, together with fire.
    launch(300, 440);
    pixelX = 11'd0; pixelY = 11'd0;
    gameOver = 1'b1; fire = 1'b1; tick();
    check("gameover_idle", {7'b0, busy}, 8'h00);
    check("gameover_nodraw", {7'b0, projectileDrawingRequest}, 8'h00);
    fire = 1'b1; tick();
    check("gameover_blocks_fire", {7'b0, busy}, 8'h00);
    gameOver = 1'b0; tick();

    // Right edge at pixel 2047 must not overflow.
    launch(2033, 100);
    pixelX = 11'd2047; pixelY = 11'd92; tick();
    check("edge2047_draw", {7'b0, projectileDrawingRequest}, 8'h01);
    pixelX = 11'd0; tick();
    check("edge_wrap_out", {7'b0, projectileDrawingRequest}, 8'h00);
    gameOver = 1'b1; tick(); gameOver = 1'b0;

    // Collision together with a frame tick at topY=100.
    launch(300, 108);
    pixelX = 11'd314; pixelY = 11'd107;
    collision = 1'b1; startOfFrame = 1'b1; tick();
    check("hit_count_1", hitCount, 8'd1);
    tick();
`ifdef PROJECTILE_EXPLODE_EN
    check("explode_draw", {7'b0, projectileDrawingRequest}, 8'h01);
    check("explode_rgb", projectileRGB, 8'hE0);
    for (int i = 0; i < EXPLODE_FRAMES - 1; i++) begin
      startOfFrame = 1'b1; tick();
    end
    check("explode_still_busy", {7'b0, busy}, 8'h01);
    startOfFrame = 1'b1; tick();
    check("explode_done", {7'b0, busy}, 8'h00);
`else
    check("hit_direct_idle", {7'b0, busy}, 8'h00);
    check("hit_no_draw", {7'b0, projectileDrawingRequest}, 8'h00);
`endif

    // Saturate the hit counter.
    for (int i = 0; i < 256; i++) begin
      launch(100, 300);
      collision = 1'b1; tick();
      gameOver = 1'b1; tick(); gameOver = 1'b0;
    end
    check("hits_saturated", hitCount, 8'd255);

    // Reset in the middle of an explosion (or right after the hit).
    launch(300, 108);
    pixelX = 11'd314; pixelY = 11'd107;
    collision = 1'b1; tick();
    reset = 1'b1; tick();
    check("midreset_busy", {7'b0, busy}, 8'h00);
    check("midreset_draw", {7'b0, projectileDrawingRequest}, 8'h00);
    check("midreset_rgb", projectileRGB, 8'h00);
    check("midreset_hits", hitCount, 8'h00);
    reset = 1'b0;

    // Randomized traffic; pixels aimed near the modelled box to exercise its edges.
    for (int i = 0; i < 4000; i++) begin
      reset        = ($urandom_range(0, 499) == 0);
      gameOver     = ($urandom_range(0, 99) == 0);
      fire         = ($urandom_range(0, 7) == 0);
      startOfFrame = ($urandom_range(0, 5) == 0);
      collision    = ($urandom_range(0, 19) == 0);
      shipX        = 11'($urandom_range(0, 2047));
      shipY        = ($urandom_range(0, 9) == 0) ? 11'($urandom_range(0, 15))
                                                 : 11'($urandom_range(0, 479));
      if ($urandom_range(0, 3) != 0) begin
        pixelX = 11'(m_x + int'($urandom_range(0, PROJ_W + 3)) - 2);
        pixelY = 11'(m_y + int'($urandom_range(0, PROJ_H + 3)) - 2);
      end else begin
        pixelX = 11'($urandom_range(0, 2047));
        pixelY = 11'($urandom_range(0, 2047));
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/projectile_move.md
PROJECTILE_MOVE -- requirements
Module: projectile_move

Interface
REQ-001 SHALL have parameter SPEED, default 4, meaning pixels moved upward per frame.
REQ-002 SHALL have parameter PROJ_W, default 4, meaning projectile width in pixels.
REQ-003 SHALL have parameter PROJ_H, default 8, meaning projectile height in pixels.
REQ-004 SHALL have parameter LAUNCH_X_OFS, default 14, meaning x offset from shipX to the projectile left edge.
REQ-005 SHALL have parameter FLY_COLOR, default 8'hFC, meaning RGB of the flying projectile.
REQ-006 SHALL have parameter EXPLODE_COLOR, default 8'hE0, meaning RGB during explosion.
REQ-007 SHALL have parameter EXPLODE_FRAMES, default 8, meaning explosion duration in frames.
REQ-008 clk  input  1  system clock; one clock, all logic on rising edge.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 startOfFrame  input  1  one-cycle pulse per video frame.
REQ-011 fire  input  1  one-cycle fire request from player input.
REQ-012 shipX, shipY  input  11 each  spaceship top-left, unsigned.
REQ-013 pixelX, pixelY  input  11 each  current VGA pixel coordinate, unsigned.
REQ-014 collision  input  1  hit pulse from the collision unit.
REQ-015 gameOver  input  1  game-over level.
REQ-016 projectileDrawingRequest  output  1  pixel lies inside the projectile box; consumed by the objects mux.
REQ-017 projectileRGB  output  8  colour for the current pixel.
REQ-018 busy  output  1  high in any state other than IDLE.
REQ-019 hitCount  output  8  number of collisions registered, saturating.

Function
REQ-020 SHALL implement states IDLE, ARMED, FLYING, EXPLODE.
REQ-021 IDLE: fire=1 SHALL latch launch position (X = shipX+LAUNCH_X_OFS, Y = shipY-PROJ_H) and move to ARMED next cycle.
REQ-022 IDLE: if shipY < PROJ_H, fire SHALL be ignored.
REQ-023 ARMED: on startOfFrame SHALL move to FLYING without changing position.
REQ-024 FLYING: on startOfFrame with topY >= SPEED, topY SHALL decrease by SPEED; with topY < SPEED, SHALL move to IDLE (no underflow/wrap).
REQ-025 FLYING: collision=1 SHALL move to EXPLODE, reset frame counter to 0, and increment hitCount, saturating at 255.
REQ-026 EXPLODE: frame counter SHALL increment on each startOfFrame; SHALL return to IDLE on the startOfFrame where the counter reaches EXPLODE_FRAMES-1.
REQ-027 collision outside FLYING SHALL be ignored; fire outside IDLE SHALL be ignored (no queuing).
REQ-028 collision and startOfFrame in the same cycle SHALL resolve as collision only; no position update occurs.
REQ-029 gameOver=1 SHALL force IDLE next cycle from any state and SHALL block fire; gameOver takes priority over all other inputs.
REQ-030 Drawing request SHALL be registered with 1 cycle latency: high the cycle after pixelX in [X, X+PROJ_W-1] and pixelY in [topY, topY+PROJ_H-1], only in FLYING or EXPLODE.
REQ-031 projectileRGB SHALL be FLY_COLOR in FLYING and EXPLODE_COLOR in EXPLODE, registered alongside the drawing request; it SHALL be 8'h00 when the request is low.
REQ-032 Bounds arithmetic SHALL use 12-bit widths so that X+PROJ_W does not overflow at pixel 2047.

Reset
REQ-033 reset=1 SHALL set state IDLE, X=0, topY=0, frame counter 0, hitCount 0, projectileDrawingRequest 0, projectileRGB 8'h00, busy 0.
REQ-034 reset SHALL take priority over all inputs, including mid-flight and mid-explosion.

Configuration
REQ-035 With macro PROJECTILE_EXPLODE_EN defined, EXPLODE behaves per REQ-025/026.
REQ-036 Without PROJECTILE_EXPLODE_EN, collision in FLYING SHALL go directly to IDLE (hitCount still increments), and EXPLODE_COLOR is unused.

Verification
REQ-037 Reset, then shipX=300, shipY=440, fire pulse, startOfFrame -> FLYING at X=314, topY=432; after 1 more frame topY=428.
REQ-038 Pixel (314,432) in FLYING -> request=1, RGB=8'hFC one cycle later; pixel (318,432) -> request=0, RGB=8'h00.
REQ-039 topY=2, startOfFrame -> IDLE, busy=0, no wrap to high Y values.
REQ-040 Collision and startOfFrame in the same cycle at topY=100 -> EXPLODE, topY stays 100, hitCount=1; after 8 frames -> IDLE (with macro); without macro -> IDLE immediately.
REQ-041 gameOver=1 during FLYING together with fire -> IDLE next cycle, request stays 0, fire ignored.
REQ-042 256 hits -> hitCount holds 255; reset mid-EXPLODE -> all outputs at reset values next cycle.
